// File: rtl/riscv_core_pkg.sv
// Shared core types: instruction word plus the reservation-station entry layout.
package riscv_core_pkg;
  localparam int XLEN      = 32;
  localparam int ROB_TAG_W = 4;

  typedef logic [31:0] riscv_instr_t;

  typedef struct packed {
    logic                 rdy;
    logic [XLEN-1:0]      value;
    logic [ROB_TAG_W-1:0] tag;
  } rs_src_t;

  typedef struct packed {
    logic                 valid;
    riscv_instr_t         opcode;
    logic [ROB_TAG_W-1:0] rob_tag;
    rs_src_t              rs1;
    rs_src_t              rs2;
  } rs_entry_t;
endpackage

// File: rtl/reservation_station.sv
// Compacting age-ordered reservation station: CDB wakeup, oldest-ready issue.
module reservation_station
  import riscv_core_pkg::*;
#(
  parameter int DATA_WIDTH     = XLEN,
  parameter int ROB_SIZE       = 16,
  parameter int ROB_ADDR_WIDTH = $clog2(ROB_SIZE),
  parameter int RS_SIZE        = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          dispatch_valid_i,
  output logic                          dispatch_ready_o,
  input  riscv_instr_t                  dispatch_opcode_i,
  input  logic [ROB_ADDR_WIDTH-1:0]     dispatch_rob_tag_i,
  input  logic                          dispatch_rs1_ready_i,
  input  logic                          dispatch_rs2_ready_i,
  input  logic [DATA_WIDTH-1:0]         dispatch_rs1_value_i,
  input  logic [DATA_WIDTH-1:0]         dispatch_rs2_value_i,
  input  logic [ROB_ADDR_WIDTH-1:0]     dispatch_rs1_tag_i,
  input  logic [ROB_ADDR_WIDTH-1:0]     dispatch_rs2_tag_i,
  input  logic                          cdb_valid_i,
  input  logic [ROB_ADDR_WIDTH-1:0]     cdb_rob_tag_i,
  input  logic [DATA_WIDTH-1:0]         cdb_data_i,
  output logic                          issue_valid_o,
  input  logic                          issue_ready_i,
  output riscv_instr_t                  issue_opcode_o,
  output logic [DATA_WIDTH-1:0]         issue_v_rs1_o,
  output logic [DATA_WIDTH-1:0]         issue_v_rs2_o,
  output logic [ROB_ADDR_WIDTH-1:0]     issue_rob_tag_o,
  output logic [$clog2(RS_SIZE+1)-1:0]  rs_count_o
);
  localparam int CW = $clog2(RS_SIZE+1);
  localparam int SW = $clog2(RS_SIZE);

  rs_entry_t         q       [RS_SIZE];
  rs_entry_t         up      [RS_SIZE];
  rs_entry_t         shifted [RS_SIZE];
  rs_entry_t         nq      [RS_SIZE];
  rs_entry_t         disp_e;
  logic [CW-1:0]     count, wr_idx;
  logic [RS_SIZE-1:0] rdy_vec;
  logic [SW-1:0]     sel;
  logic              issue_fire, disp_fire;

  function automatic rs_src_t wake(rs_src_t s, logic en);
    rs_src_t r = s;
    if (en && !s.rdy && cdb_valid_i && s.tag == cdb_rob_tag_i) begin
      r.rdy   = 1'b1;
      r.value = cdb_data_i;
    end
    return r;
  endfunction

  // Lowest index wins: entry 0 is always the oldest.
  always_comb begin
    sel = '0;
    for (int i = 0; i < RS_SIZE; i++)
      rdy_vec[i] = q[i].valid & q[i].rs1.rdy & q[i].rs2.rdy;
    for (int i = RS_SIZE-1; i >= 0; i--)
      if (rdy_vec[i]) sel = SW'(i);
  end

  assign issue_valid_o    = (|rdy_vec) && !flush_i;
  assign issue_fire       = issue_valid_o && issue_ready_i;
  assign dispatch_ready_o = count < CW'(RS_SIZE);
  assign disp_fire        = dispatch_valid_i && dispatch_ready_o && !flush_i;
  assign wr_idx           = count - CW'(issue_fire);
  assign rs_count_o       = count;

  assign issue_opcode_o  = issue_valid_o ? q[sel].opcode    : '0;
  assign issue_v_rs1_o   = issue_valid_o ? q[sel].rs1.value : '0;
  assign issue_v_rs2_o   = issue_valid_o ? q[sel].rs2.value : '0;
  assign issue_rob_tag_o = issue_valid_o ? q[sel].rob_tag   : '0;

  always_comb begin
    disp_e         = '0;
    disp_e.valid   = 1'b1;
    disp_e.opcode  = dispatch_opcode_i;
    disp_e.rob_tag = dispatch_rob_tag_i;
    disp_e.rs1     = wake('{dispatch_rs1_ready_i, dispatch_rs1_value_i, dispatch_rs1_tag_i}, 1'b1);
    disp_e.rs2     = wake('{dispatch_rs2_ready_i, dispatch_rs2_value_i, dispatch_rs2_tag_i}, 1'b1);
  end

  // Compact over the issued slot, wake the survivors, then append the dispatch.
  always_comb begin
    for (int i = 0; i < RS_SIZE-1; i++) up[i] = q[i+1];
    up[RS_SIZE-1] = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      shifted[i]  = (issue_fire && i >= int'(sel)) ? up[i] : q[i];
      nq[i]       = shifted[i];
      nq[i].rs1   = wake(shifted[i].rs1, shifted[i].valid);
      nq[i].rs2   = wake(shifted[i].rs2, shifted[i].valid);
      if (disp_fire && CW'(i) == wr_idx) nq[i] = disp_e;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      count <= '0;
      for (int i = 0; i < RS_SIZE; i++) q[i] <= '0;
    end else begin
      count <= count + CW'(disp_fire) - CW'(issue_fire);
      for (int i = 0; i < RS_SIZE; i++) q[i] <= nq[i];
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// Random + directed stimulus against a queue-based model of the reservation station.
module tb_reservation_station;
  import riscv_core_pkg::*;
  localparam int RS = 4;

  logic clk = 1'b0;
  logic rst, flush, dv, r1r, r2r, cv, ir;
  logic [31:0] op, v1, v2, cd;
  logic [3:0]  dt, t1, t2, ct;
  logic        dr, iv;
  logic [31:0] iop, iv1, iv2;
  logic [3:0]  itag;
  logic [2:0]  cnt;

  reservation_station dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .dispatch_valid_i(dv), .dispatch_ready_o(dr), .dispatch_opcode_i(op),
    .dispatch_rob_tag_i(dt), .dispatch_rs1_ready_i(r1r), .dispatch_rs2_ready_i(r2r),
    .dispatch_rs1_value_i(v1), .dispatch_rs2_value_i(v2),
    .dispatch_rs1_tag_i(t1), .dispatch_rs2_tag_i(t2),
    .cdb_valid_i(cv), .cdb_rob_tag_i(ct), .cdb_data_i(cd),
    .issue_valid_o(iv), .issue_ready_i(ir), .issue_opcode_o(iop),
    .issue_v_rs1_o(iv1), .issue_v_rs2_o(iv2), .issue_rob_tag_o(itag),
    .rs_count_o(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op; logic [3:0] tag;
    bit r1; logic [31:0] v1; logic [3:0] t1;
    bit r2; logic [31:0] v2; logic [3:0] t2;
  } m_t;
  m_t mq[$];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int oldest();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  task automatic idle();
    {rst, flush, dv, r1r, r2r, cv, ir} = '0;
    op = '0; v1 = '0; v2 = '0; cd = '0; dt = '0; t1 = '0; t2 = '0; ct = '0;
  endtask

  // Called just after a negedge with inputs set: check outputs, then advance the model at posedge.
  task automatic step();
    int  o;
    bit  e_iv, dfire;
    m_t  e;
    #1;
    o    = oldest();
    e_iv = (o >= 0) && !flush && !rst;
    if (!rst) begin
      chk("issue_valid", iv, e_iv);
      chk("issue_opcode", iop, e_iv ? mq[o].op : 0);
      chk("issue_v_rs1", iv1, e_iv ? mq[o].v1 : 0);
      chk("issue_v_rs2", iv2, e_iv ? mq[o].v2 : 0);
      chk("issue_rob_tag", itag, e_iv ? 32'(mq[o].tag) : 0);
      chk("rs_count", cnt, mq.size());
      chk("dispatch_ready", dr, mq.size() < RS);
    end
    @(posedge clk);
    if (rst || flush) mq.delete();
    else begin
      dfire = dv && mq.size() < RS;
      if (e_iv && ir) mq.delete(o);
      foreach (mq[i]) begin
        if (cv && !mq[i].r1 && mq[i].t1 == ct) begin mq[i].r1 = 1; mq[i].v1 = cd; end
        if (cv && !mq[i].r2 && mq[i].t2 == ct) begin mq[i].r2 = 1; mq[i].v2 = cd; end
      end
      if (dfire) begin
        e = '{op, dt, r1r, v1, t1, r2r, v2, t2};
        if (cv && !e.r1 && e.t1 == ct) begin e.r1 = 1; e.v1 = cd; end
        if (cv && !e.r2 && e.t2 == ct) begin e.r2 = 1; e.v2 = cd; end
        mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic disp(input logic [3:0] tag, input bit a, input logic [3:0] ta, input bit b, input logic [3:0] tb);
    dv = 1; op = 32'h0000_0033 | (32'(tag) << 7); dt = tag;
    r1r = a; v1 = 32'h100 + 32'(tag); t1 = ta;
    r2r = b; v2 = 32'h200 + 32'(tag); t2 = tb;
  endtask

  initial begin
    idle(); rst = 1;
    @(negedge clk);
    step();                      // reset edge
    idle(); #1;
    chk("rst_count", cnt, 0); chk("rst_iv", iv, 0); chk("rst_dr", dr, 1);
    chk("rst_opcode", iop, 0); chk("rst_tag", itag, 0);

    // Ready dispatch
    disp(4'd3, 1, 0, 1, 0); v1 = 5; v2 = 7; ir = 1; step();
    idle(); ir = 1; #1;
    chk("rd_iv", iv, 1); chk("rd_v1", iv1, 5); chk("rd_v2", iv2, 7); chk("rd_tag", itag, 3);
    step(); #1; chk("rd_count", cnt, 0);

    // CDB wakeup
    idle(); disp(4'd5, 0, 4'd9, 1, 0); ir = 1; step();
    idle(); ir = 1; step();
    chk("wk_pre_iv", iv, 0);
    cv = 1; ct = 9; cd = 32'hDEAD; step();
    idle(); ir = 1; #1;
    chk("wk_iv", iv, 1); chk("wk_v1", iv1, 32'hDEAD);
    step();

    // Dispatch-time capture
    idle(); disp(4'd6, 1, 0, 0, 4'd4); cv = 1; ct = 4; cd = 32'h11; ir = 1; step();
    idle(); ir = 1; #1;
    chk("cap_iv", iv, 1); chk("cap_v2", iv2, 32'h11);
    step();

    // Full and age order
    idle();
    for (int k = 1; k <= 4; k++) begin disp(4'(k), 0, 4'(10 + k), 1, 0); step(); end
    idle(); #1; chk("full_dr", dr, 0);
    disp(4'd7, 1, 0, 1, 0); step(); step();
    chk("full_held", cnt, 4);
    idle(); cv = 1; ct = 12; cd = 32'hA2; step();
    idle(); cv = 1; ct = 14; cd = 32'hA4; step();
    idle(); ir = 1; #1; chk("age_tag2", itag, 2);
    step(); #1; chk("age_cnt3", cnt, 3); chk("age_tag4", itag, 4);
    step(); #1; chk("age_cnt2", cnt, 2);

    // Simultaneous issue/dispatch/wakeup at count 3
    idle(); disp(4'd8, 1, 0, 1, 0); step();
    idle(); ir = 1; cv = 1; ct = 13; cd = 32'hB3; step();  // wakes tag3, tag1 stays waiting
    idle(); #1; chk("sim_cnt", cnt, 2);

    // Flush with entries, one ready
    idle(); disp(4'd9, 1, 0, 1, 0); step();
    idle(); flush = 1; ir = 1; #1; chk("fl_iv", iv, 0);
    step(); idle(); #1; chk("fl_cnt", cnt, 0);

    // Reset mid-operation
    disp(4'd10, 1, 0, 0, 4'd2); step(); disp(4'd11, 1, 0, 1, 0); step();
    idle(); rst = 1; step();
    idle(); #1;
    chk("rs_cnt", cnt, 0); chk("rs_iv", iv, 0); chk("rs_v1", iv1, 0); chk("rs_v2", iv2, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      if ($urandom_range(1)) disp(4'($urandom_range(15)), $urandom_range(2) == 0, 4'($urandom_range(7)),
                                   $urandom_range(2) == 0, 4'($urandom_range(7)));
      v1 = $urandom; v2 = $urandom;
      cv = $urandom_range(1); ct = 4'($urandom_range(7)); cd = $urandom;
      ir = $urandom_range(3) != 0;
      flush = $urandom_range(60) == 0;
      rst = $urandom_range(250) == 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
